// File: rtl/uart_tx_stream.sv
// Buffered UART transmitter: valid/ready stream into a FIFO, frames
// serialised back-to-back with configurable data width, parity and stop bits.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | line high, waiting for the FIFO to hold a word
// S_START  | start bit (tx = 0) for TICKS cycles
// S_DATA   | data bits, LSB first, TICKS cycles each
// S_PARITY | parity bit for TICKS cycles (never entered when PARITY = 0)
// S_STOP   | stop bit(s), tx = 1 for STOP_BITS * TICKS cycles
module uart_tx_stream #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUDRATE   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_BITS-1:0]        s_data,
  input  logic                        s_valid,
  output logic                        s_ready,
  output logic                        tx,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int TICKS      = CLK_FREQ / BAUDRATE;
  localparam int STOP_TICKS = STOP_BITS * TICKS;
  localparam int CW         = $clog2(STOP_TICKS);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int CNTW       = AW + 1;
  localparam int BW         = $clog2(DATA_BITS);

  // Baud counter is a down-counter; a bit ends when it reaches zero.
  localparam logic [CW-1:0]   BIT_LOAD  = CW'(TICKS - 1);
  localparam logic [CW-1:0]   STOP_LOAD = CW'(STOP_TICKS - 1);
  localparam logic [BW-1:0]   LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic [CNTW-1:0] FULL      = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wptr;
  logic [AW-1:0]        r_rptr;
  logic [CNTW-1:0]      r_count;
  logic                 r_ready;

  state_t               r_state;
  logic [CW-1:0]        r_baud;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par;
  logic                 r_tx;
  logic                 r_done;

  state_t               w_state_nxt;
  logic [CW-1:0]        w_baud_nxt;
  logic [BW-1:0]        w_bit_nxt;
  logic                 w_tx_nxt;
  logic                 w_done_nxt;
  logic                 w_pop;
  logic                 w_shift;
  logic                 w_push;
  logic                 w_tc;
  logic                 w_has_word;
  logic [CNTW-1:0]      w_count_nxt;
  logic [DATA_BITS-1:0] w_head;
  logic                 w_head_par;

  assign w_push     = s_valid && r_ready;
  assign w_has_word = (r_count != '0);
  assign w_tc       = (r_baud == '0);
  assign w_head     = r_mem[r_rptr];
  // Odd parity makes the total number of ones odd, even makes it even.
  assign w_head_par = (PARITY == 1) ? ~^w_head : ^w_head;

  // FIFO occupancy after this edge's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNTW'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNTW'(1);
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= s_data;
    end
  end

  // FIFO pointers, occupancy and the registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ready <= 1'b1;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt < FULL);
    end
  end

  // Next-state, next line value and FIFO pop for the frame sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = w_tc ? '0 : r_baud - CW'(1);
    w_bit_nxt   = r_bit;
    w_tx_nxt    = r_tx;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_has_word) begin
          w_pop       = 1'b1;
          w_tx_nxt    = 1'b0;
          w_baud_nxt  = BIT_LOAD;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_tc) begin
          w_tx_nxt    = r_shift[0];
          w_bit_nxt   = '0;
          w_baud_nxt  = BIT_LOAD;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_tc) begin
          if (r_bit == LAST_BIT) begin
            if (PARITY != 0) begin
              w_tx_nxt    = r_par;
              w_baud_nxt  = BIT_LOAD;
              w_state_nxt = S_PARITY;
            end else begin
              w_tx_nxt    = 1'b1;
              w_baud_nxt  = STOP_LOAD;
              w_state_nxt = S_STOP;
            end
          end else begin
            w_shift    = 1'b1;
            w_tx_nxt   = r_shift[1];
            w_bit_nxt  = r_bit + BW'(1);
            w_baud_nxt = BIT_LOAD;
          end
        end
      end
      S_PARITY: begin
        if (w_tc) begin
          w_tx_nxt    = 1'b1;
          w_baud_nxt  = STOP_LOAD;
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_tc) begin
          w_done_nxt = 1'b1;
          // A queued word starts its start bit on this same edge.
          if (w_has_word) begin
            w_pop       = 1'b1;
            w_tx_nxt    = 1'b0;
            w_baud_nxt  = BIT_LOAD;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_tx_nxt    = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Sequencer state, baud/bit counters, shift register and line outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_bit   <= w_bit_nxt;
      r_tx    <= w_tx_nxt;
      r_done  <= w_done_nxt;
      if (w_pop) begin
        r_shift <= w_head;
        r_par   <= w_head_par;
      end else if (w_shift) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

  assign s_ready    = r_ready;
  assign tx         = r_tx;
  assign busy       = (r_state != S_IDLE);
  assign tx_done    = r_done;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: three instances cover 8N1 (depth 4),
// 7E2 and 9O1 (TICKS = 3, depth 2). Accepted words go to a queue; a line
// monitor per instance rebuilds each expected frame and compares it cycle
// by cycle against tx, busy and tx_done.
module tb_uart_tx_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] sv = '0;
  logic [7:0] sd0 = '0;
  logic [6:0] sd1 = '0;
  logic [8:0] sd2 = '0;
  wire  [2:0] srdy;
  wire  [2:0] txw;
  wire  [2:0] busyw;
  wire  [2:0] donew;
  wire  [2:0] fc0;
  wire  [4:0] fc1;
  wire  [1:0] fc2;

  int         n_checks = 0;
  int         n_fail = 0;
  int         done_cnt [3] = '{0, 0, 0};
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;

  uart_tx_stream #(.CLK_FREQ(1000000), .BAUDRATE(100000), .DATA_BITS(8),
                   .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .s_data(sd0), .s_valid(sv[0]), .s_ready(srdy[0]),
    .tx(txw[0]), .busy(busyw[0]), .tx_done(donew[0]), .fifo_count(fc0));

  uart_tx_stream #(.CLK_FREQ(1000000), .BAUDRATE(100000), .DATA_BITS(7),
                   .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .s_data(sd1), .s_valid(sv[1]), .s_ready(srdy[1]),
    .tx(txw[1]), .busy(busyw[1]), .tx_done(donew[1]), .fifo_count(fc1));

  uart_tx_stream #(.CLK_FREQ(1000000), .BAUDRATE(333333), .DATA_BITS(9),
                   .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .s_data(sd2), .s_valid(sv[2]), .s_ready(srdy[2]),
    .tx(txw[2]), .busy(busyw[2]), .tx_done(donew[2]), .fifo_count(fc2));

  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) if (donew[u] === 1'b1) done_cnt[u] <= done_cnt[u] + 1;
  end

  function automatic int fcnt(input int u);
    case (u)
      0:       return int'(fc0);
      1:       return int'(fc1);
      default: return int'(fc2);
    endcase
  endfunction

  task automatic set_data(input int u, input logic [8:0] d);
    case (u)
      0:       sd0 = d[7:0];
      1:       sd1 = d[6:0];
      default: sd2 = d;
    endcase
  endtask

  // Offer one word (caller is at a falling edge); queue it once accepted.
  task automatic send(input int u, input logic [8:0] d);
    int guard;
    logic [8:0] m;
    case (u)
      0:       m = d & 9'h0FF;
      1:       m = d & 9'h07F;
      default: m = d;
    endcase
    set_data(u, m);
    sv[u] = 1'b1;
    guard = 0;
    while (srdy[u] !== 1'b1 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    n_checks++;
    if (guard >= 2000) begin
      n_fail++;
      $display("FAIL send_accept unit %0d: s_ready stayed %b, required 1", u, srdy[u]);
    end else begin
      exp_q.push_back(m);
    end
    @(negedge clk);
    sv[u] = 1'b0;
  endtask

  task automatic wait_idle(input int u, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && busyw[u] === 1'b0 && fcnt(u) == 0) break;
    end
    n_checks++;
    if (i >= budget) begin
      n_fail++;
      $display("FAIL wait_idle unit %0d: busy %b queued %0d after %0d cycles, required idle",
               u, busyw[u], exp_q.size(), budget);
    end
    repeat (2) @(negedge clk);
  endtask

  // Rebuilds each frame from the queued word and checks every cycle of it.
  task automatic monitor(input int u, input int ticks, input int nb, input int par,
                         input int nstop);
    logic [8:0]  exp_w;
    logic [15:0] bits;
    logic [15:0] obs;
    int          nbits;
    int          ones;
    bit          ok;
    bit          aborted;
    bit          have;
    have = 1'b0;
    forever begin
      if (!have) @(negedge clk);
      have = 1'b0;
      if (rst_n === 1'b1 && txw[u] === 1'b0) begin
        exp_w = '0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_frame unit %0d: start bit seen, required none", u);
        end else begin
          exp_w = exp_q.pop_front();
        end
        nbits = 1 + nb + ((par != 0) ? 1 : 0) + nstop;
        bits = '1;
        bits[0] = 1'b0;
        ones = 0;
        for (int i = 0; i < nb; i++) begin
          bits[1+i] = exp_w[i];
          ones += int'(exp_w[i]);
        end
        if (par == 1) bits[1+nb] = (ones % 2 == 0);
        else if (par == 2) bits[1+nb] = (ones % 2 == 1);
        ok = 1'b1;
        aborted = 1'b0;
        obs = '1;
        for (int b = 0; b < nbits && !aborted; b++) begin
          for (int t = 0; t < ticks && !aborted; t++) begin
            if (b != 0 || t != 0) @(negedge clk);
            if (rst_n !== 1'b1) begin
              aborted = 1'b1;
            end else begin
              if (t == ticks / 2) obs[b] = txw[u];
              if (txw[u] !== bits[b] || busyw[u] !== 1'b1) ok = 1'b0;
              if ((b != 0 || t != 0) && donew[u] !== 1'b0) ok = 1'b0;
            end
          end
        end
        if (!aborted) begin
          @(negedge clk);
          n_checks++;
          if (!ok) begin
            n_fail++;
            $display("FAIL frame_bits unit %0d: line %b, required %b (bit0 = start)", u, obs, bits);
          end
          n_checks++;
          if (donew[u] !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_length unit %0d: tx_done %b after %0d cycles, required 1",
                     u, donew[u], nbits * ticks);
          end
          have = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    for (int pass = 0; pass < 2; pass++) begin
      for (int u = 0; u < 3; u++) begin
        n_checks++;
        if (txw[u] !== 1'b1 || busyw[u] !== 1'b0 || donew[u] !== 1'b0 ||
            srdy[u] !== 1'b1 || fcnt(u) != 0) begin
          n_fail++;
          $display("FAIL reset_state unit %0d pass %0d: tx %b busy %b done %b ready %b count %0d, required 1 0 0 1 0",
                   u, pass, txw[u], busyw[u], donew[u], srdy[u], fcnt(u));
        end
      end
      if (pass == 0) begin
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
      end
    end
  endtask

  task automatic test_basic_8n1();
    int i;
    @(negedge clk);
    sd0 = 8'h55;
    sv[0] = 1'b1;
    exp_q.push_back(9'h055);
    @(negedge clk);
    sv[0] = 1'b0;
    n_checks++;
    if (fcnt(0) != 1 || busyw[0] !== 1'b0 || txw[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_push: count %0d busy %b tx %b, required 1 0 1", fcnt(0), busyw[0], txw[0]);
    end
    @(negedge clk);
    n_checks++;
    if (fcnt(0) != 0 || busyw[0] !== 1'b1 || txw[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_pop: count %0d busy %b tx %b, required 0 1 0", fcnt(0), busyw[0], txw[0]);
    end
    for (i = 0; i < 150; i++) begin
      @(negedge clk);
      if (donew[0] === 1'b1) break;
    end
    n_checks++;
    if (i >= 150 || busyw[0] !== 1'b0 || txw[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_end: done seen %0d busy %b tx %b, required done, 0, 1", (i < 150), busyw[0], txw[0]);
    end
    @(negedge clk);
    n_checks++;
    if (donew[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: tx_done %b one cycle later, required 0", donew[0]);
    end
  endtask

  task automatic test_back_to_back();
    int d;
    int extra;
    bit held;
    @(negedge clk);
    send(0, 9'h0A5);
    send(0, 9'h03C);
    send(0, 9'h0FF);
    d = 0;
    held = 1'b1;
    for (int i = 0; i < 400 && d < 3; i++) begin
      @(negedge clk);
      if (donew[0] === 1'b1) d++;
      if (d < 3 && busyw[0] !== 1'b1) held = 1'b0;
    end
    n_checks++;
    if (!held) begin
      n_fail++;
      $display("FAIL b2b_busy_held: busy dropped between frames, required held high");
    end
    n_checks++;
    if (busyw[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_busy_end: busy %b at last tx_done, required 0", busyw[0]);
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (donew[0] === 1'b1) extra++;
    end
    n_checks++;
    if (d + extra != 3) begin
      n_fail++;
      $display("FAIL b2b_done_count: %0d tx_done pulses, required 3", d + extra);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int first_low;
    int low_count;
    bit saw;
    bit glitch;
    acc = 0;
    first_low = -1;
    low_count = -1;
    saw = 1'b0;
    glitch = 1'b0;
    @(negedge clk);
    sv[0] = 1'b1;
    for (int idx = 0; idx < 400; idx++) begin
      sd0 = 8'h10 + 8'(acc);
      if (donew[0] === 1'b1) begin
        saw = 1'b1;
        break;
      end
      if (srdy[0] !== 1'b1 && first_low < 0) begin
        first_low = idx;
        low_count = fcnt(0);
      end
      if (srdy[0] === 1'b1 && first_low >= 0) glitch = 1'b1;
      if (srdy[0] === 1'b1) begin
        exp_q.push_back(9'(8'h10 + 8'(acc)));
        acc++;
      end
      @(negedge clk);
    end
    sv[0] = 1'b0;
    n_checks++;
    if (acc != 5) begin
      n_fail++;
      $display("FAIL bp_accepted: %0d words accepted, required 5", acc);
    end
    n_checks++;
    if (first_low != 5 || low_count != 4) begin
      n_fail++;
      $display("FAIL bp_ready_low: s_ready low from edge E+%0d with count %0d, required E+4 with 4",
               first_low - 1, low_count);
    end
    n_checks++;
    if (!saw || glitch || srdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready_release: done seen %b early rise %b ready %b, required 1 0 1", saw, glitch, srdy[0]);
    end
    wait_idle(0, 1000);
  endtask

  task automatic test_reset_mid();
    int base;
    bit quiet;
    @(negedge clk);
    send(0, 9'h011);
    send(0, 9'h022);
    send(0, 9'h033);
    repeat (43) @(negedge clk);
    base = done_cnt[0];
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (txw[0] !== 1'b1 || busyw[0] !== 1'b0 || fcnt(0) != 0 || srdy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: tx %b busy %b count %0d ready %b, required 1 0 0 1",
               txw[0], busyw[0], fcnt(0), srdy[0]);
    end
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (150) begin
      @(negedge clk);
      if (txw[0] !== 1'b1 || busyw[0] !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (!quiet || done_cnt[0] != base) begin
      n_fail++;
      $display("FAIL reset_discard: line active %b, %0d extra tx_done, required 0 and 0",
               !quiet, done_cnt[0] - base);
    end
    @(negedge clk);
    send(0, 9'h05A);
    wait_idle(0, 300);
  endtask

  task automatic test_even_parity_2stop();
    int base;
    base = done_cnt[1];
    @(negedge clk);
    send(1, 9'h007);
    send(1, 9'h003);
    wait_idle(1, 600);
    n_checks++;
    if (done_cnt[1] - base != 2) begin
      n_fail++;
      $display("FAIL e2_done_count: %0d tx_done pulses, required 2", done_cnt[1] - base);
    end
  endtask

  task automatic test_odd_parity_9bit();
    int base;
    base = done_cnt[2];
    @(negedge clk);
    send(2, 9'h1FF);
    send(2, 9'h000);
    send(2, 9'h101);
    wait_idle(2, 400);
    n_checks++;
    if (done_cnt[2] - base != 3) begin
      n_fail++;
      $display("FAIL o9_done_count: %0d tx_done pulses, required 3", done_cnt[2] - base);
    end
  endtask

  initial begin
    fork
      monitor(0, 10, 8, 0, 1);
      monitor(1, 10, 7, 2, 2);
      monitor(2, 3, 9, 1, 1);
    join_none
    test_reset();
    test_basic_8n1();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_even_parity_2stop();
    test_odd_parity_9bit();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_words: %0d words never framed, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_stream.md
# uart_tx_stream

Parametrised, buffered UART transmitter for the greenflow FPGA telemetry path. It accepts words over a valid/ready stream into an internal FIFO and serialises them back-to-back on a single TX line. Frame format is configurable: data width, optional odd or even parity, and one or two stop bits. It sits between the telemetry packetiser and the board UART pin, and replaces the single-byte, unbuffered transmitter.

## Interface
- CLK_FREQ, 50000000: clock frequency in Hz.
- BAUDRATE, 115200: line rate in baud. TICKS = CLK_FREQ/BAUDRATE (integer division), and TICKS must be ≥ 2.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: FIFO entries; must be a power of two, ≥ 2.

- clk  in  1  system clock; all logic is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_data  in  DATA_BITS  word to transmit.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  FIFO can accept a word; registered, high when fifo_count < FIFO_DEPTH.
- tx  out  1  serial line, idles high; registered.
- busy  out  1  high while a frame is on the line (FSM not IDLE).
- tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Push: a word is written when s_valid && s_ready at a clock edge. s_data is ignored otherwise. No overflow is possible; a word offered while s_ready is low stays pending at the source.
- FSM states: IDLE → START → DATA → PARITY (skipped when PARITY = 0) → STOP → IDLE or START.
- IDLE with fifo_count ≠ 0: pop the head word into the shift register, drive tx = 0, and go to START.
- Each bit holds tx for exactly TICKS cycles, timed by a baud counter that resets on every bit transition.
- DATA: LSB first, DATA_BITS bits.
- PARITY: the odd setting drives ~^data; the even setting drives ^data, so the total count of ones including the parity bit is odd or even respectively.
- STOP: tx = 1 for STOP_BITS × TICKS cycles. At the end of the period, tx_done pulses. If the FIFO is non-empty, the next word is popped and the START bit begins on that same edge, with no idle gap. Otherwise the FSM returns to IDLE.
- Simultaneous push and pop: fifo_count is unchanged; the pushed word goes to the tail.
- Read and write pointers wrap modulo FIFO_DEPTH.

## Timing
- Reset values: tx = 1, busy = 0, tx_done = 0, s_ready = 1, fifo_count = 0. The FIFO is emptied, the FSM is in IDLE, and the counters are 0.
- Reset asserted mid-frame aborts the frame immediately (asynchronously): tx goes high and queued words are discarded.
- Latency: a push accepted at edge E into an empty FIFO with the FSM in IDLE gives tx falling and busy rising at edge E+1. fifo_count reads 1 after E and 0 after E+1.
- Frame length is (1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS) × TICKS cycles, measured from the start-bit edge to the tx_done edge.
- tx_done is high for exactly one cycle, in the cycle following the final stop-bit edge.
- busy falls on the same edge that tx_done is asserted, unless another frame starts on that edge.
- s_ready follows fifo_count with no combinational path from s_valid.

## Test plan
- Basic 8N1 frame: CLK_FREQ=1000000, BAUDRATE=100000 (TICKS=10). Push 0x55 → tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 10 cycles, 100 cycles total; then one tx_done pulse; busy then low.
- Even parity with 2 stop bits: DATA_BITS=7, PARITY=2, STOP_BITS=2. Push 0x07 → start bit, data 1,1,1,0,0,0,0, parity bit 1, then two stop bits; 11 × TICKS cycles total.
- Back-to-back: push 0xA5, 0x3C, 0xFF on consecutive edges → three frames with no idle cycle between them. tx_done pulses exactly 3 times, and busy stays high throughout.
- Backpressure: FIFO_DEPTH=4, s_valid held high from edge E → exactly 5 words accepted (the first is popped at E+1). s_ready is low from E+4 until the first frame's tx_done. All words are transmitted in order.
- Reset mid-frame: assert rst_n low during the 4th data bit with 2 words queued → tx=1, busy=0, fifo_count=0 immediately. After release, no frames are sent until a new push.
- Odd parity with 9 data bits: DATA_BITS=9, PARITY=1. Push 0x1FF → parity bit 0. Push 0x000 → parity bit 1.
